// File: rtl/rob_commit_unit.sv
// Reorder buffer with in-order retire: issue allocates at the tail, CDB marks
// entries done, and the head retires one completed entry per cycle.
module rob_commit_unit #(
    parameter int DEPTH  = 128,
    parameter int TAG_W  = 7,
    parameter int DATA_W = 32,
    parameter int IDX_W  = 11
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              alloc_valid,
    output logic              alloc_ready,
    input  logic [4:0]        alloc_dest,
    input  logic [IDX_W-1:0]  alloc_index,
    output logic [TAG_W-1:0]  alloc_tag,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_value,
    output logic              commit_valid,
    output logic              commit_wen,
    output logic [4:0]        commit_dest,
    output logic [DATA_W-1:0] commit_value,
    output logic [TAG_W-1:0]  commit_tag,
    output logic [IDX_W-1:0]  commit_index,
    output logic [TAG_W:0]    count,
    output logic              full,
    output logic              empty
);

    typedef enum logic [1:0] {
        SLOT_FREE = 2'd0,
        SLOT_WAIT = 2'd1,
        SLOT_DONE = 2'd2
    } slot_state_t;

    slot_state_t       slot_state [DEPTH];
    logic [4:0]        dest_mem   [DEPTH];
    logic [IDX_W-1:0]  index_mem  [DEPTH];
    logic [DATA_W-1:0] value_mem  [DEPTH];

    logic [TAG_W-1:0] head;
    logic [TAG_W-1:0] tail;
    logic             alloc_fire;
    logic             cdb_hit;
    logic             retire;

    // Allocation handshake: an entry is granted on a clock edge where
    // alloc_valid && alloc_ready; alloc_tag is the granted tag in that cycle.
    // alloc_ready depends only on registered count, so a same-cycle retire
    // never frees a slot for a same-cycle allocation.
    assign full        = (count == (TAG_W+1)'(DEPTH));
    assign empty       = (count == '0);
    assign alloc_ready = !full;
    assign alloc_tag   = tail;

    assign alloc_fire = alloc_valid && alloc_ready;
    assign cdb_hit    = cdb_valid && (slot_state[cdb_tag] != SLOT_FREE);
    assign retire     = (slot_state[head] == SLOT_DONE);

    // Per-slot state machine plus head/tail/count and the registered retire port.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            commit_valid <= 1'b0;
            commit_wen   <= 1'b0;
            commit_dest  <= '0;
            commit_value <= '0;
            commit_tag   <= '0;
            commit_index <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slot_state[i] <= SLOT_FREE;
            end
        end else begin
            commit_valid <= retire;
            commit_wen   <= retire && (dest_mem[head] != 5'd0);
            if (retire) begin
                commit_dest  <= dest_mem[head];
                commit_value <= value_mem[head];
                commit_tag   <= head;
                commit_index <= index_mem[head];
            end

            if (alloc_fire) begin
                slot_state[tail] <= SLOT_WAIT;
                tail             <= tail + 1'b1;
            end

            // A late CDB hit on the retiring head must not resurrect it,
            // so the retire update is placed after the CDB update.
            if (cdb_hit) begin
                slot_state[cdb_tag] <= SLOT_DONE;
            end

            if (retire) begin
                slot_state[head] <= SLOT_FREE;
                head             <= head + 1'b1;
            end

            case ({alloc_fire, retire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset; slot_state decides what is live.
    always_ff @(posedge clock) begin
        if (alloc_fire) begin
            dest_mem[tail]  <= alloc_dest;
            index_mem[tail] <= alloc_index;
        end
        if (cdb_hit) begin
            value_mem[cdb_tag] <= cdb_value;
        end
    end

endmodule

// File: tb/tb_rob_commit_unit.sv
// Directed bench for rob_commit_unit: expected retires are queued at stimulus
// time and a negedge monitor pops and compares every commit pulse.
module tb_rob_commit_unit;

    logic        clock;
    logic        reset;
    logic        flush;
    logic        alloc_valid;
    logic        alloc_ready;
    logic [4:0]  alloc_dest;
    logic [10:0] alloc_index;
    logic [6:0]  alloc_tag;
    logic        cdb_valid;
    logic [6:0]  cdb_tag;
    logic [31:0] cdb_value;
    logic        commit_valid;
    logic        commit_wen;
    logic [4:0]  commit_dest;
    logic [31:0] commit_value;
    logic [6:0]  commit_tag;
    logic [10:0] commit_index;
    logic [7:0]  count;
    logic        full;
    logic        empty;

    logic [55:0] exp_q[$];
    int total = 0;
    int bad = 0;
    int n_commits = 0;
    int snap;

    rob_commit_unit dut (
        .clock(clock), .reset(reset), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
        .alloc_dest(alloc_dest), .alloc_index(alloc_index), .alloc_tag(alloc_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .commit_valid(commit_valid), .commit_wen(commit_wen),
        .commit_dest(commit_dest), .commit_value(commit_value),
        .commit_tag(commit_tag), .commit_index(commit_index),
        .count(count), .full(full), .empty(empty)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [55:0] make_exp(input logic wen, input logic [4:0] d,
                                             input logic [6:0] t, input logic [10:0] idx,
                                             input logic [31:0] v);
        return {wen, d, t, idx, v};
    endfunction

    // driver tasks
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_alloc(input logic [4:0] d, input logic [10:0] idx);
        alloc_valid = 1'b1;
        alloc_dest  = d;
        alloc_index = idx;
        tick();
        alloc_valid = 1'b0;
    endtask

    task automatic do_cdb(input logic [6:0] t, input logic [31:0] v);
        cdb_valid = 1'b1;
        cdb_tag   = t;
        cdb_value = v;
        tick();
        cdb_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_count(input int target, input string name);
        int n = 0;
        while ((int'(count) != target || exp_q.size() != 0) && n < 50) begin
            tick();
            n++;
        end
        check(name, 64'(count), 64'(target));
        check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    // scoreboard monitor
    always @(negedge clock) begin
        if (!reset && commit_valid) begin
            n_commits++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_commit: tag=%0d value=0x%0h, none expected",
                         commit_tag, commit_value);
            end else begin
                check("commit", {8'd0, commit_wen, commit_dest, commit_tag, commit_index, commit_value},
                      {8'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        alloc_valid = 1'b0;
        alloc_dest = '0;
        alloc_index = '0;
        cdb_valid = 1'b0;
        cdb_tag = '0;
        cdb_value = '0;

        // T1 reset
        tick();
        tick();
        check("t1_empty", 64'(empty), 64'd1);
        check("t1_count", 64'(count), 64'd0);
        check("t1_alloc_tag", 64'(alloc_tag), 64'd0);
        check("t1_commit_valid", 64'(commit_valid), 64'd0);
        check("t1_full", 64'(full), 64'd0);
        check("t1_alloc_ready", 64'(alloc_ready), 64'd1);
        reset = 1'b0;

        // T2 in-order retire
        do_alloc(5'd5, 11'd100);
        check("t2_tag1", 64'(alloc_tag), 64'd1);
        do_alloc(5'd6, 11'd101);
        check("t2_count", 64'(count), 64'd2);
        do_cdb(7'd1, 32'h22);
        tick();
        tick();
        check("t2_no_early_commit", 64'(n_commits), 64'd0);
        exp_q.push_back(make_exp(1'b1, 5'd5, 7'd0, 11'd100, 32'h11));
        exp_q.push_back(make_exp(1'b1, 5'd6, 7'd1, 11'd101, 32'h22));
        do_cdb(7'd0, 32'h11);
        check("t2_latency_cycle1", 64'(commit_valid), 64'd0);
        tick();
        check("t2_first_valid", 64'(commit_valid), 64'd1);
        check("t2_first_dest", 64'(commit_dest), 64'd5);
        tick();
        check("t2_second_valid", 64'(commit_valid), 64'd1);
        check("t2_second_dest", 64'(commit_dest), 64'd6);
        tick();
        check("t2_pulse_end", 64'(commit_valid), 64'd0);
        wait_count(0, "t2_drain");

        // T3 full and wrap
        do_reset();
        alloc_valid = 1'b1;
        for (int i = 0; i < 128; i++) begin
            alloc_dest  = 5'((i % 31) + 1);
            alloc_index = 11'(i);
            tick();
        end
        check("t3_count_full", 64'(count), 64'd128);
        check("t3_full", 64'(full), 64'd1);
        check("t3_ready_low", 64'(alloc_ready), 64'd0);
        check("t3_empty_low", 64'(empty), 64'd0);
        alloc_dest  = 5'd31;
        alloc_index = 11'd999;
        tick();
        check("t3_refused_count", 64'(count), 64'd128);
        check("t3_refused_tag", 64'(alloc_tag), 64'd0);
        exp_q.push_back(make_exp(1'b1, 5'd1, 7'd0, 11'd0, 32'h55));
        do_cdb(7'd0, 32'h55);
        tick();
        check("t3_refused_on_commit", 64'(count), 64'd127);
        check("t3_wrap_tag", 64'(alloc_tag), 64'd0);
        tick();
        alloc_valid = 1'b0;
        check("t3_realloc_count", 64'(count), 64'd128);
        check("t3_after_wrap_tag", 64'(alloc_tag), 64'd1);
        check("t3_drained", 64'(exp_q.size()), 64'd0);

        // T4 x0 destination
        do_reset();
        check("t4_reset_count", 64'(count), 64'd0);
        do_alloc(5'd0, 11'd7);
        exp_q.push_back(make_exp(1'b0, 5'd0, 7'd0, 11'd7, 32'hDEAD));
        do_cdb(7'd0, 32'hDEAD);
        wait_count(0, "t4_drain");

        // T5 simultaneous alloc+commit, CDB to free slot, CDB overwrite
        for (int k = 1; k <= 5; k++) begin
            do_alloc(5'(k), 11'(9 + k));
        end
        check("t5_count5", 64'(count), 64'd5);
        exp_q.push_back(make_exp(1'b1, 5'd1, 7'd1, 11'd10, 32'hA1));
        do_cdb(7'd1, 32'hA1);
        do_alloc(5'd6, 11'd15);
        check("t5_alloc_and_commit", 64'(count), 64'd5);
        check("t5_tail", 64'(alloc_tag), 64'd7);
        tick();
        snap = n_commits;
        do_cdb(7'd100, 32'hBAD);
        repeat (4) tick();
        check("t5_free_cdb_count", 64'(count), 64'd5);
        check("t5_free_cdb_no_commit", 64'(n_commits), 64'(snap));
        exp_q.push_back(make_exp(1'b1, 5'd2, 7'd2, 11'd11, 32'hB2));
        exp_q.push_back(make_exp(1'b1, 5'd3, 7'd3, 11'd12, 32'hB3));
        do_cdb(7'd3, 32'h1);
        do_cdb(7'd3, 32'hB3);
        do_cdb(7'd2, 32'hB2);
        wait_count(3, "t5_drain");

        // T6 flush with three entries, two done
        do_cdb(7'd5, 32'h55);
        do_cdb(7'd6, 32'h66);
        check("t6_pre_flush_count", 64'(count), 64'd3);
        snap = n_commits;
        flush = 1'b1;
        alloc_valid = 1'b1;
        alloc_dest = 5'd9;
        cdb_valid = 1'b1;
        cdb_tag = 7'd4;
        cdb_value = 32'h44;
        tick();
        flush = 1'b0;
        alloc_valid = 1'b0;
        cdb_valid = 1'b0;
        check("t6_count", 64'(count), 64'd0);
        check("t6_empty", 64'(empty), 64'd1);
        check("t6_alloc_tag", 64'(alloc_tag), 64'd0);
        repeat (4) tick();
        check("t6_no_commit", 64'(n_commits), 64'(snap));
        exp_q.push_back(make_exp(1'b1, 5'd3, 7'd0, 11'd33, 32'h77));
        do_alloc(5'd3, 11'd33);
        check("t6_next_tag", 64'(alloc_tag), 64'd1);
        do_cdb(7'd0, 32'h77);
        wait_count(0, "t6_drain");

        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
